// File: rtl/mtm_alu_frame_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : mtm_alu_frame_rx_if                                          |
// | Purpose   : Result/error bus of the ALU serial packet receiver.          |
// |             The receiver drives the master side; the consumer of        |
// |             decoded operations sits on the slave side.                  |
// | Signals   : out_valid / out_ready  valid/ready handshake                 |
// |             out_a, out_b           operands, 8*N_BYTES bits each         |
// |             out_op                 3-bit opcode                          |
// |             out_err                {ERR_DATA, ERR_CRC, ERR_OP}           |
// |             overrun                one-cycle pulse, result dropped       |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface mtm_alu_frame_rx_if #(
   parameter int N_BYTES = 4
) ();
   localparam int W = 8 * N_BYTES;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_a;
   logic [W-1:0] out_b;
   logic [2:0]   out_op;
   logic [2:0]   out_err;
   logic         overrun;

   modport master (
      output out_valid,
      input  out_ready,
      output out_a,
      output out_b,
      output out_op,
      output out_err,
      output overrun
   );

   modport slave (
      input  out_valid,
      output out_ready,
      input  out_a,
      input  out_b,
      input  out_op,
      input  out_err,
      input  overrun
   );
endinterface
`default_nettype wire

// File: rtl/mtm_alu_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mtm_alu_frame_rx                                              |
// | Purpose  : Serial packet receiver for the ALU input path. Deserialises   |
// |            11-bit frames (start, type, 8 payload bits MSB first, stop),  |
// |            assembles operands B then A (N_BYTES each, MSB byte first)    |
// |            and a command byte, checks frame count, CRC4 and opcode, and  |
// |            presents a decoded operation or an error code on a            |
// |            valid/ready bus.                                              |
// | Ports    : clk      clock, posedge                                       |
// |            rst      synchronous active-high reset                        |
// |            sin      serial input, idle high                              |
// |            bus      mtm_alu_frame_rx_if.master result/error bus          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mtm_alu_frame_rx #(
   parameter int N_BYTES     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sin,
   mtm_alu_frame_rx_if.master bus
);

   localparam int W  = 8 * N_BYTES;
   localparam int CW = $clog2(2 * N_BYTES + 1);
   localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [CW-1:0] FULL_CNT  = CW'(2 * N_BYTES);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
   localparam logic [3:0]    STOP_IDX  = 4'd9;

   localparam logic [2:0] ERR_NONE = 3'b000;
   localparam logic [2:0] ERR_DATA = 3'b100;
   localparam logic [2:0] ERR_CRC  = 3'b010;
   localparam logic [2:0] ERR_OP   = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RX        = 2'd1,
      S_CHECK     = 2'd2,
      S_WAIT_HIGH = 2'd3
   } state_t;

   // One serial step of CRC4, polynomial x^4+x+1.
   function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
      logic fb;
      fb = d ^ c[3];
      return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
   endfunction

   // Frame-level state
   state_t          state_q,   state_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic            is_cmd_q,  is_cmd_d;
   logic [7:0]      shreg_q,   shreg_d;
   logic [3:0]      crc_q,     crc_d;
   logic [CW-1:0]   cnt_q,     cnt_d;
   logic [2*W-1:0]  data_q,    data_d;
   logic [IW-1:0]   idle_q,    idle_d;

   // Result produced on the stop-bit edge, presented one edge later
   logic            res_vld_q, res_vld_d;
   logic [2:0]      res_err_q, res_err_d;
   logic [2:0]      res_op_q,  res_op_d;

   // Output registers
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_a_q,     out_a_d;
   logic [W-1:0]    out_b_q,     out_b_d;
   logic [2:0]      out_op_q,    out_op_d;
   logic [2:0]      out_err_q,   out_err_d;
   logic            overrun_q,   overrun_d;

   logic [2:0]      cmd_op;
   logic [3:0]      cmd_crc;
   logic [3:0]      crc_final;
   logic            op_ok;
   logic            accept;

   assign cmd_op  = shreg_q[6:4];
   assign cmd_crc = shreg_q[3:0];
   assign accept  = out_valid_q && bus.out_ready;

   // The CMD frame folds the marker bit and the opcode into the running CRC.
   always_comb begin : p_crc_fold
      crc_final = crc_q;
      crc_final = crc4_step(crc_final, 1'b1);
      crc_final = crc4_step(crc_final, cmd_op[2]);
      crc_final = crc4_step(crc_final, cmd_op[1]);
      crc_final = crc4_step(crc_final, cmd_op[0]);
   end

   always_comb begin : p_op_ok
      op_ok = 1'b0;
      case (cmd_op)
         3'b000, 3'b001, 3'b100, 3'b101: op_ok = 1'b1;
         default:                        op_ok = 1'b0;
      endcase
   end

   always_comb begin : p_frame
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      is_cmd_d  = is_cmd_q;
      shreg_d   = shreg_q;
      crc_d     = crc_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      idle_d    = '0;
      res_vld_d = 1'b0;
      res_err_d = res_err_q;
      res_op_d  = res_op_q;

      case (state_q)
         // CHECK behaves like IDLE for start detection so that a start bit
         // right after a stop bit is never missed.
         S_IDLE, S_CHECK: begin
            if (!sin) begin
               state_d   = S_RX;
               bit_cnt_d = '0;
            end else if (state_q == S_CHECK) begin
               state_d = S_IDLE;
            end else if (TIMEOUT_CYC != 0 && cnt_q != '0) begin
               if (idle_q == IDLE_LAST) begin
                  res_vld_d = 1'b1;
                  res_err_d = ERR_DATA;
                  res_op_d  = '0;
                  cnt_d     = '0;
                  crc_d     = '0;
               end else begin
                  idle_d = idle_q + IW'(1);
               end
            end
         end

         S_RX: begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd0) begin
               is_cmd_d = sin;
            end else if (bit_cnt_q != STOP_IDX) begin
               shreg_d = {shreg_q[6:0], sin};
               if (!is_cmd_q) begin
                  crc_d = crc4_step(crc_q, sin);
               end
            end else if (!sin) begin
               // Broken stop bit: drop the packet and resynchronise on idle.
               state_d   = S_WAIT_HIGH;
               res_vld_d = 1'b1;
               res_err_d = ERR_DATA;
               res_op_d  = '0;
               cnt_d     = '0;
               crc_d     = '0;
            end else begin
               state_d = S_CHECK;
               if (!is_cmd_q) begin
                  if (cnt_q == FULL_CNT) begin
                     // One DATA frame too many: report now, restart packet.
                     res_vld_d = 1'b1;
                     res_err_d = ERR_DATA;
                     res_op_d  = '0;
                     cnt_d     = '0;
                     crc_d     = '0;
                  end else begin
                     data_d = {data_q[2*W-9:0], shreg_q};
                     cnt_d  = cnt_q + CW'(1);
                  end
               end else begin
                  res_vld_d = 1'b1;
                  res_op_d  = '0;
                  if (cnt_q != FULL_CNT) begin
                     res_err_d = ERR_DATA;
                  end else if (crc_final != cmd_crc) begin
                     res_err_d = ERR_CRC;
                  end else if (!op_ok) begin
                     res_err_d = ERR_OP;
                  end else begin
                     res_err_d = ERR_NONE;
                     res_op_d  = cmd_op;
                  end
                  cnt_d = '0;
                  crc_d = '0;
               end
            end
         end

         S_WAIT_HIGH: begin
            if (sin) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Output handshake: a pending result loads when the bus is free or being
   // accepted on this edge; otherwise it is dropped and overrun pulses.
   always_comb begin : p_out
      out_valid_d = out_valid_q && !accept;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_op_d    = out_op_q;
      out_err_d   = out_err_q;
      overrun_d   = 1'b0;

      if (res_vld_q) begin
         if (!out_valid_q || accept) begin
            out_valid_d = 1'b1;
            out_err_d   = res_err_q;
            out_op_d    = res_op_q;
            if (res_err_q == ERR_NONE) begin
               out_b_d = data_q[2*W-1:W];
               out_a_d = data_q[W-1:0];
            end else begin
               out_b_d = '0;
               out_a_d = '0;
            end
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         is_cmd_q    <= 1'b0;
         shreg_q     <= '0;
         crc_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         idle_q      <= '0;
         res_vld_q   <= 1'b0;
         res_err_q   <= '0;
         res_op_q    <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_op_q    <= '0;
         out_err_q   <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         is_cmd_q    <= is_cmd_d;
         shreg_q     <= shreg_d;
         crc_q       <= crc_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         idle_q      <= idle_d;
         res_vld_q   <= res_vld_d;
         res_err_q   <= res_err_d;
         res_op_q    <= res_op_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_op_q    <= out_op_d;
         out_err_q   <= out_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_a     = out_a_q;
   assign bus.out_b     = out_b_q;
   assign bus.out_op    = out_op_q;
   assign bus.out_err   = out_err_q;
   assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mtm_alu_frame_rx                                           |
// | Purpose  : Directed self-checking bench for mtm_alu_frame_rx. Two        |
// |            instances: N_BYTES=4 and N_BYTES=2, both TIMEOUT_CYC=16.      |
// |            Inputs change and outputs are sampled on the falling edge.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mtm_alu_frame_rx;

   logic clk;
   logic rst;
   logic sin4;
   logic sin2;
   int   total;
   int   bad;

   mtm_alu_frame_rx_if #(.N_BYTES(4)) bus4 ();
   mtm_alu_frame_rx_if #(.N_BYTES(2)) bus2 ();

   mtm_alu_frame_rx #(.N_BYTES(4), .TIMEOUT_CYC(16)) dut4 (
      .clk (clk),
      .rst (rst),
      .sin (sin4),
      .bus (bus4)
   );

   mtm_alu_frame_rx #(.N_BYTES(2), .TIMEOUT_CYC(16)) dut2 (
      .clk (clk),
      .rst (rst),
      .sin (sin2),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {valid, err, op, a, b}
   logic [70:0] obs4;
   logic [38:0] obs2;
   assign obs4 = {bus4.out_valid, bus4.out_err, bus4.out_op, bus4.out_a, bus4.out_b};
   assign obs2 = {bus2.out_valid, bus2.out_err, bus2.out_op, bus2.out_a, bus2.out_b};

   // Accepted results, {err, op, a, b}
   logic [69:0] q4[$];
   logic [37:0] q2[$];
   always @(negedge clk) begin
      if (bus4.out_valid && bus4.out_ready)
         q4.push_back({bus4.out_err, bus4.out_op, bus4.out_a, bus4.out_b});
      if (bus2.out_valid && bus2.out_ready)
         q2.push_back({bus2.out_err, bus2.out_op, bus2.out_a, bus2.out_b});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before the end of the test sequence");
      $fatal(1, "watchdog expired");
   end

   // Reference CRC by long division of the augmented message {B, A, 1, op, 0000}.
   function automatic logic [4:0] div_step(input logic [4:0] r, input logic d);
      logic [4:0] t;
      t = {r[3:0], d};
      if (t[4]) t = t ^ 5'b10011;
      return t;
   endfunction

   function automatic logic [3:0] crc_ref(input int nb, input logic [31:0] b,
                                          input logic [31:0] a, input logic [2:0] op);
      logic [4:0] r;
      r = 5'd0;
      for (int i = 8*nb-1; i >= 0; i--) r = div_step(r, b[i]);
      for (int i = 8*nb-1; i >= 0; i--) r = div_step(r, a[i]);
      r = div_step(r, 1'b1);
      for (int i = 2; i >= 0; i--) r = div_step(r, op[i]);
      for (int i = 0; i < 4; i++) r = div_step(r, 1'b0);
      return r[3:0];
   endfunction

   task automatic drive_bit(input int sel, input logic v);
      @(negedge clk);
      if (sel == 2) sin2 = v;
      else          sin4 = v;
   endtask

   task automatic send_frame(input int sel, input logic typ, input logic [7:0] pl, input logic stopb);
      drive_bit(sel, 1'b0);
      drive_bit(sel, typ);
      for (int i = 7; i >= 0; i--) drive_bit(sel, pl[i]);
      drive_bit(sel, stopb);
   endtask

   // DATA frames in order: B MSB byte first, then A; any extra frames carry 0x5A.
   task automatic send_data(input int sel, input int nb, input logic [31:0] b,
                            input logic [31:0] a, input int nframes);
      logic [7:0] byt;
      for (int i = 0; i < nframes; i++) begin
         if (i < nb)          byt = b[8*(nb-1-i) +: 8];
         else if (i < 2*nb)   byt = a[8*(2*nb-1-i) +: 8];
         else                 byt = 8'h5A;
         send_frame(sel, 1'b0, byt, 1'b1);
      end
   endtask

   task automatic send_packet(input int sel, input int nb, input logic [31:0] b,
                              input logic [31:0] a, input logic [2:0] op, input logic [3:0] crc);
      send_data(sel, nb, b, a, 2*nb);
      send_frame(sel, 1'b1, {1'b0, op, crc}, 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sin4 = 1'b1;
      sin2 = 1'b1;
      bus4.out_ready = 1'b1;
      bus2.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({obs4, bus4.overrun} !== 72'd0) begin
         bad++;
         $display("FAIL reset_n4: got %h expected 0", {obs4, bus4.overrun});
      end
      total++;
      if ({obs2, bus2.overrun} !== 40'd0) begin
         bad++;
         $display("FAIL reset_n2: got %h expected 0", {obs2, bus2.overrun});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_valid_add();
      send_packet(4, 4, 32'h22222222, 32'h11111111, 3'b100,
                  crc_ref(4, 32'h22222222, 32'h11111111, 3'b100));
      @(negedge clk);
      total++;
      if (bus4.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL add_early: out_valid=%b expected 0 one edge after stop", bus4.out_valid);
      end
      @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b000, 3'b100, 32'h11111111, 32'h22222222}) begin
         bad++;
         $display("FAIL add_result: got %h expected %h", obs4,
                  {1'b1, 3'b000, 3'b100, 32'h11111111, 32'h22222222});
      end
      @(negedge clk);
      total++;
      if (bus4.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL add_one_cycle: out_valid=%b expected 0 after acceptance", bus4.out_valid);
      end
   endtask

   task automatic test_bad_crc();
      logic [3:0] good;
      logic [3:0] wrong;
      good  = crc_ref(4, 32'h22222222, 32'h11111111, 3'b100);
      wrong = (good == 4'h0) ? 4'h5 : 4'h0;
      send_packet(4, 4, 32'h22222222, 32'h11111111, 3'b100, wrong);
      repeat (2) @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b010, 3'b000, 64'd0}) begin
         bad++;
         $display("FAIL bad_crc: got %h expected %h", obs4, {1'b1, 3'b010, 3'b000, 64'd0});
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_bad_op();
      send_packet(4, 4, 32'h22222222, 32'h11111111, 3'b010,
                  crc_ref(4, 32'h22222222, 32'h11111111, 3'b010));
      repeat (2) @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b001, 3'b000, 64'd0}) begin
         bad++;
         $display("FAIL bad_op: got %h expected %h", obs4, {1'b1, 3'b001, 3'b000, 64'd0});
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frame_count();
      // 7 DATA frames then CMD
      send_data(4, 4, 32'hA1B2C3D4, 32'h01020304, 7);
      send_frame(4, 1'b1, {1'b0, 3'b100, 4'h3}, 1'b1);
      repeat (2) @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b100, 3'b000, 64'd0}) begin
         bad++;
         $display("FAIL short_packet: got %h expected %h", obs4, {1'b1, 3'b100, 3'b000, 64'd0});
      end
      repeat (2) @(negedge clk);
      // 9 DATA frames, no CMD: error right after the 9th stop bit
      send_data(4, 4, 32'hA1B2C3D4, 32'h01020304, 9);
      repeat (2) @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b100, 3'b000, 64'd0}) begin
         bad++;
         $display("FAIL long_packet: got %h expected %h", obs4, {1'b1, 3'b100, 3'b000, 64'd0});
      end
      repeat (2) @(negedge clk);
      send_packet(4, 4, 32'h00000007, 32'hFFFFFFF0, 3'b101,
                  crc_ref(4, 32'h00000007, 32'hFFFFFFF0, 3'b101));
      repeat (2) @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b000, 3'b101, 32'hFFFFFFF0, 32'h00000007}) begin
         bad++;
         $display("FAIL after_long_packet: got %h expected %h", obs4,
                  {1'b1, 3'b000, 3'b101, 32'hFFFFFFF0, 32'h00000007});
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      int n;
      int i;
      send_data(4, 4, 32'h12345678, 32'h9ABCDEF0, 3);
      n = 0;
      i = 0;
      while (n == 0 && i < 40) begin
         @(negedge clk);
         i++;
         if (bus4.out_valid) n = i;
      end
      total++;
      if (n < 16 || n > 20) begin
         bad++;
         $display("FAIL timeout_latency: got %0d cycles expected 16..20", n);
      end
      total++;
      if (obs4 !== {1'b1, 3'b100, 3'b000, 64'd0}) begin
         bad++;
         $display("FAIL timeout_err: got %h expected %h", obs4, {1'b1, 3'b100, 3'b000, 64'd0});
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_bad_stop();
      int seen;
      send_frame(4, 1'b0, 8'hA5, 1'b0);
      repeat (2) @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b100, 3'b000, 64'd0}) begin
         bad++;
         $display("FAIL bad_stop: got %h expected %h", obs4, {1'b1, 3'b100, 3'b000, 64'd0});
      end
      // Line stays low: the receiver must wait for high, not start new frames.
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus4.out_valid) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL wait_high: got %0d results while sin low expected 0", seen);
      end
      sin4 = 1'b1;
      repeat (2) @(negedge clk);
      send_packet(4, 4, 32'h00000000, 32'hFFFFFFFF, 3'b001,
                  crc_ref(4, 32'h00000000, 32'hFFFFFFFF, 3'b001));
      repeat (2) @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b000, 3'b001, 32'hFFFFFFFF, 32'h00000000}) begin
         bad++;
         $display("FAIL after_bad_stop: got %h expected %h", obs4,
                  {1'b1, 3'b000, 3'b001, 32'hFFFFFFFF, 32'h00000000});
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_packet();
      send_data(4, 4, 32'hDEADBEEF, 32'h00000000, 5);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++;
      if (obs4 !== 71'd0) begin
         bad++;
         $display("FAIL reset_mid: got %h expected 0", obs4);
      end
      @(negedge clk);
      send_packet(4, 4, 32'h0000FFFF, 32'hFFFF0000, 3'b000,
                  crc_ref(4, 32'h0000FFFF, 32'hFFFF0000, 3'b000));
      repeat (2) @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 3'b000, 3'b000, 32'hFFFF0000, 32'h0000FFFF}) begin
         bad++;
         $display("FAIL after_reset_mid: got %h expected %h", obs4,
                  {1'b1, 3'b000, 3'b000, 32'hFFFF0000, 32'h0000FFFF});
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_backpressure();
      int ov;
      bus4.out_ready = 1'b0;
      send_packet(4, 4, 32'h22222222, 32'h11111111, 3'b100,
                  crc_ref(4, 32'h22222222, 32'h11111111, 3'b100));
      repeat (2) @(negedge clk);
      send_packet(4, 4, 32'h00000005, 32'h00000003, 3'b101,
                  crc_ref(4, 32'h00000005, 32'h00000003, 3'b101));
      ov = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus4.overrun) ov++;
      end
      total++;
      if (ov !== 1) begin
         bad++;
         $display("FAIL overrun_pulse: got %0d pulses expected 1", ov);
      end
      total++;
      if (obs4 !== {1'b1, 3'b000, 3'b100, 32'h11111111, 32'h22222222}) begin
         bad++;
         $display("FAIL held_result: got %h expected %h", obs4,
                  {1'b1, 3'b000, 3'b100, 32'h11111111, 32'h22222222});
      end
      bus4.out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus4.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain: out_valid=%b expected 0", bus4.out_valid);
      end
      bus4.out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_same_edge_accept();
      bus4.out_ready = 1'b0;
      send_packet(4, 4, 32'h22222222, 32'h11111111, 3'b100,
                  crc_ref(4, 32'h22222222, 32'h11111111, 3'b100));
      repeat (2) @(negedge clk);
      send_packet(4, 4, 32'h80000000, 32'h00000001, 3'b101,
                  crc_ref(4, 32'h80000000, 32'h00000001, 3'b101));
      @(negedge clk);
      bus4.out_ready = 1'b1;
      @(negedge clk);
      bus4.out_ready = 1'b0;
      total++;
      if ({obs4, bus4.overrun} !== {1'b1, 3'b000, 3'b101, 32'h00000001, 32'h80000000, 1'b0}) begin
         bad++;
         $display("FAIL same_edge: got %h expected %h", {obs4, bus4.overrun},
                  {1'b1, 3'b000, 3'b101, 32'h00000001, 32'h80000000, 1'b0});
      end
      @(negedge clk);
      total++;
      if ({obs4, bus4.overrun} !== {1'b1, 3'b000, 3'b101, 32'h00000001, 32'h80000000, 1'b0}) begin
         bad++;
         $display("FAIL same_edge_hold: got %h expected %h", {obs4, bus4.overrun},
                  {1'b1, 3'b000, 3'b101, 32'h00000001, 32'h80000000, 1'b0});
      end
      bus4.out_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      q4.delete();
      send_packet(4, 4, 32'h22222222, 32'h11111111, 3'b100,
                  crc_ref(4, 32'h22222222, 32'h11111111, 3'b100));
      send_packet(4, 4, 32'hCAFEF00D, 32'h0BADBEEF, 3'b000,
                  crc_ref(4, 32'hCAFEF00D, 32'h0BADBEEF, 3'b000));
      repeat (5) @(negedge clk);
      total++;
      if (q4.size() !== 2) begin
         bad++;
         $display("FAIL b2b_count: got %0d results expected 2", q4.size());
      end
      if (q4.size() == 2) begin
         total++;
         if (q4[0] !== {3'b000, 3'b100, 32'h11111111, 32'h22222222}) begin
            bad++;
            $display("FAIL b2b_first: got %h expected %h", q4[0],
                     {3'b000, 3'b100, 32'h11111111, 32'h22222222});
         end
         total++;
         if (q4[1] !== {3'b000, 3'b000, 32'h0BADBEEF, 32'hCAFEF00D}) begin
            bad++;
            $display("FAIL b2b_second: got %h expected %h", q4[1],
                     {3'b000, 3'b000, 32'h0BADBEEF, 32'hCAFEF00D});
         end
      end
   endtask

   task automatic test_width2();
      logic [15:0] wb [4];
      logic [15:0] wa [4];
      logic [2:0]  wop[4];
      int ov;
      wb  = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
      wa  = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
      wop = '{3'b000, 3'b001, 3'b100, 3'b101};
      q2.delete();
      for (int i = 0; i < 4; i++)
         send_packet(2, 2, {16'h0, wb[i]}, {16'h0, wa[i]}, wop[i],
                     crc_ref(2, {16'h0, wb[i]}, {16'h0, wa[i]}, wop[i]));
      repeat (5) @(negedge clk);
      total++;
      if (q2.size() !== 4) begin
         bad++;
         $display("FAIL n2_count: got %0d results expected 4", q2.size());
      end
      if (q2.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (q2[i] !== {3'b000, wop[i], wa[i], wb[i]}) begin
               bad++;
               $display("FAIL n2_op%0d: got %h expected %h", i, q2[i], {3'b000, wop[i], wa[i], wb[i]});
            end
         end
      end
      // Backpressure on the narrow instance
      bus2.out_ready = 1'b0;
      send_packet(2, 2, 32'h0000FFFF, 32'h00000001, 3'b100,
                  crc_ref(2, 32'h0000FFFF, 32'h00000001, 3'b100));
      repeat (2) @(negedge clk);
      send_packet(2, 2, 32'h00001111, 32'h00002222, 3'b001,
                  crc_ref(2, 32'h00001111, 32'h00002222, 3'b001));
      ov = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus2.overrun) ov++;
      end
      total++;
      if (ov !== 1) begin
         bad++;
         $display("FAIL n2_overrun: got %0d pulses expected 1", ov);
      end
      total++;
      if (obs2 !== {1'b1, 3'b000, 3'b100, 16'h0001, 16'hFFFF}) begin
         bad++;
         $display("FAIL n2_held: got %h expected %h", obs2, {1'b1, 3'b000, 3'b100, 16'h0001, 16'hFFFF});
      end
      bus2.out_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_valid_add();
      test_bad_crc();
      test_bad_op();
      test_frame_count();
      test_timeout();
      test_bad_stop();
      test_reset_mid_packet();
      test_backpressure();
      test_same_edge_accept();
      test_back_to_back();
      test_width2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
